// File: rtl/alu_cmd_sequencer_if.sv
// Command and response streams between a host and the ALU command sequencer.
// The sequencer takes the slave view: it consumes commands and produces responses.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_q;
    logic [2:0] rsp_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_q, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_q, rsp_op
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to the ALU,
// samples the result after ALU_LAT edges and returns it in command order.
module alu_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ALU_LAT    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave cmd_if,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [2:0]         alu_op,
    input  logic [4:0]         alu_q,
    output logic [7:0]         done_cnt,
    output logic               busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int unsigned ENT_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt_c;
    logic [LAT_W-1:0] lat_cnt;
    logic             push_c;
    logic             pop_c;
    logic             idle_nxt_c;
    logic [ENT_W-1:0] head_c;

    // Handshake decode and next-cycle occupancy, used to register cmd_ready/busy
    always_comb begin
        push_c      = cmd_if.cmd_valid && cmd_if.cmd_ready;
        pop_c       = (state == IDLE) && (count != '0);
        count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
        idle_nxt_c  = ((state == IDLE) && !pop_c) ||
                      ((state == RESP) && cmd_if.rsp_ready);
        head_c      = mem[rd_ptr];
    end

    // Command storage carries no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {cmd_if.cmd_a, cmd_if.cmd_b, cmd_if.cmd_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            lat_cnt          <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            alu_op           <= '0;
            cmd_if.cmd_ready <= 1'b1;
            cmd_if.rsp_valid <= 1'b0;
            cmd_if.rsp_q     <= '0;
            cmd_if.rsp_op    <= '0;
            done_cnt         <= '0;
            busy             <= 1'b0;
        end else begin
            count            <= count_nxt_c;
            cmd_if.cmd_ready <= (count_nxt_c != CNT_W'(FIFO_DEPTH));
            busy             <= !idle_nxt_c || (count_nxt_c != '0);
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        {alu_a, alu_b, alu_op} <= head_c;
                        rd_ptr                 <= rd_ptr + PTR_W'(1);
                        lat_cnt                <= LAT_W'(ALU_LAT - 1);
                        state                  <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        cmd_if.rsp_q     <= alu_q;
                        cmd_if.rsp_op    <= alu_op;
                        cmd_if.rsp_valid <= 1'b1;
                        state            <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (cmd_if.rsp_ready) begin
                        cmd_if.rsp_valid <= 1'b0;
                        done_cnt         <= done_cnt + 8'd1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
